// File: rtl/layer_weight_mac_pkg.sv
// rtl/layer_weight_mac_pkg.sv - shared fixed-point constants, layer FSM states and saturation helper
package layer_weight_mac_pkg;

  localparam int FXP_DATA_WIDTH = 32;
  localparam int FXP_FRAC_WIDTH = 16;
  localparam int FXP_WIDE_WIDTH = 2 * FXP_DATA_WIDTH;

  // Largest and smallest representable data words, expressed in the wide domain
  localparam logic signed [FXP_WIDE_WIDTH-1:0] FXP_WIDE_MAX =
    {{(FXP_WIDE_WIDTH-FXP_DATA_WIDTH+1){1'b0}}, {(FXP_DATA_WIDTH-1){1'b1}}};
  localparam logic signed [FXP_WIDE_WIDTH-1:0] FXP_WIDE_MIN =
    {{(FXP_WIDE_WIDTH-FXP_DATA_WIDTH+1){1'b1}}, {(FXP_DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RUN  = 2'd2
  } layer_state_t;

  // Clamp a wide signed value into the signed data word range
  function automatic logic [FXP_DATA_WIDTH-1:0] saturate(input logic signed [FXP_WIDE_WIDTH-1:0] v);
    if (v > FXP_WIDE_MAX) begin
      saturate = FXP_WIDE_MAX[FXP_DATA_WIDTH-1:0];
    end else if (v < FXP_WIDE_MIN) begin
      saturate = FXP_WIDE_MIN[FXP_DATA_WIDTH-1:0];
    end else begin
      saturate = v[FXP_DATA_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/layer_weight_mac_fxp_mult_shift.sv
// rtl/layer_weight_mac_fxp_mult_shift.sv - registered signed fixed-point multiply with rescale and clamp
module fxp_mult_shift
  import layer_weight_mac_pkg::*;
#(
  parameter int DATA_WIDTH = FXP_DATA_WIDTH,
  parameter int FRAC_WIDTH = FXP_FRAC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_p
);

  logic signed [2*DATA_WIDTH-1:0] w_a_ext;
  logic signed [2*DATA_WIDTH-1:0] w_b_ext;
  logic signed [2*DATA_WIDTH-1:0] w_full;
  logic signed [2*DATA_WIDTH-1:0] w_shifted;

  // Operands are sign-extended to full width so the low half of the product is exact
  assign w_a_ext   = {{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a};
  assign w_b_ext   = {{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b};
  assign w_full    = w_a_ext * w_b_ext;
  assign w_shifted = w_full >>> FRAC_WIDTH;

  // Register the rescaled product, clamped to a data word so later sums stay within guard bits
  always_ff @(posedge clk) begin
    if (rst) begin
      o_p <= '0;
    end else if (i_en) begin
      o_p <= saturate(w_shifted);
    end
  end

endmodule

// File: rtl/layer_weight_mac.sv
// rtl/layer_weight_mac.sv - buffers a layer input vector and MACs streamed weights into per-node sums
module layer_weight_mac
  import layer_weight_mac_pkg::*;
#(
  parameter  int DATA_WIDTH = FXP_DATA_WIDTH,
  parameter  int FRAC_WIDTH = FXP_FRAC_WIDTH,
  parameter  int N_IN       = 2,
  parameter  int N_OUT      = 32,
  parameter  int GUARD_BITS = 8,
  localparam int ACC_WIDTH  = DATA_WIDTH + GUARD_BITS,
  localparam int IDX_WIDTH  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_data_valid,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_weight,
  input  logic                  i_weight_valid,
  output logic                  o_ram_enable,
  output logic                  o_rw_select,
  output logic [DATA_WIDTH-1:0] o_node_sum,
  output logic [IDX_WIDTH-1:0]  o_node_index,
  output logic                  o_node_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int PTR_WIDTH = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int K_WIDTH   = $clog2(N_IN + 1);

  localparam logic [K_WIDTH-1:0]   K_BIAS    = K_WIDTH'(N_IN);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(N_IN - 1);
  localparam logic [IDX_WIDTH-1:0] NODE_LAST = IDX_WIDTH'(N_OUT - 1);

  layer_state_t r_state;
  layer_state_t w_next_state;

  logic [DATA_WIDTH-1:0] r_buf [N_IN];
  logic [PTR_WIDTH-1:0]  r_wr_ptr;

  logic [K_WIDTH-1:0]    r_k;
  logic [IDX_WIDTH-1:0]  r_n;
  logic                  r_weights_done;

  logic                  w_take;
  logic                  w_is_bias;
  logic                  w_mul_en;
  logic [DATA_WIDTH-1:0] w_mul_a;
  logic [DATA_WIDTH-1:0] w_prod;

  logic                  r_s1_valid;
  logic                  r_s1_bias;
  logic [DATA_WIDTH-1:0] r_s1_bias_word;
  logic [IDX_WIDTH-1:0]  r_s1_node;

  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_term;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0]       w_sum_sat;

  assign o_rw_select = 1'b1;

  // Layer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state plus the read-request and busy outputs
  always_comb begin
    w_next_state = r_state;
    o_ram_enable = 1'b0;
    o_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next_state = REQ;
        end
      end
      REQ: begin
        o_ram_enable = 1'b1;
        o_busy       = 1'b1;
        w_next_state = RUN;
      end
      RUN: begin
        o_busy = 1'b1;
        if (o_done) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Input activation buffer, writable only while idle so it stays frozen during a layer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      for (int i = 0; i < N_IN; i++) begin
        r_buf[i] <= '0;
      end
    end else if ((r_state == IDLE) && i_data_valid) begin
      r_buf[r_wr_ptr] <= i_data;
      r_wr_ptr        <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    end
  end

  // A weight is consumed only in RUN and only until the whole layer has been streamed
  assign w_take    = (r_state == RUN) && i_weight_valid && !r_weights_done;
  assign w_is_bias = (r_k == K_BIAS);
  assign w_mul_en  = w_take && !w_is_bias;
  // For the bias beat the index may point past the buffer; the multiplier is disabled then
  assign w_mul_a   = r_buf[r_k[PTR_WIDTH-1:0]];

  // Weight position (k within node, node n) tracking; cleared by each read request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k            <= '0;
      r_n            <= '0;
      r_weights_done <= 1'b0;
    end else if (r_state == REQ) begin
      r_k            <= '0;
      r_n            <= '0;
      r_weights_done <= 1'b0;
    end else if (w_take) begin
      if (w_is_bias) begin
        r_k <= '0;
        if (r_n == NODE_LAST) begin
          r_weights_done <= 1'b1;
        end else begin
          r_n <= r_n + 1'b1;
        end
      end else begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  fxp_mult_shift #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_mult (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_mul_en),
    .i_a  (w_mul_a),
    .i_b  (i_weight),
    .o_p  (w_prod)
  );

  // Stage 1 control travelling alongside the registered product
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid     <= 1'b0;
      r_s1_bias      <= 1'b0;
      r_s1_bias_word <= '0;
      r_s1_node      <= '0;
    end else begin
      r_s1_valid     <= w_take;
      r_s1_bias      <= w_is_bias;
      r_s1_bias_word <= i_weight;
      r_s1_node      <= r_n;
    end
  end

  assign w_term    = r_s1_bias ? {{GUARD_BITS{r_s1_bias_word[DATA_WIDTH-1]}}, r_s1_bias_word}
                               : {{GUARD_BITS{w_prod[DATA_WIDTH-1]}}, w_prod};
  assign w_sum     = r_acc + w_term;
  assign w_sum_sat = saturate(FXP_WIDE_WIDTH'(w_sum));

  // Stage 2: accumulate; on the bias term emit the clamped sum and restart from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      o_node_sum   <= '0;
      o_node_index <= '0;
      o_node_valid <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      o_node_valid <= 1'b0;
      o_done       <= 1'b0;
      if (r_state == REQ) begin
        r_acc <= '0;
      end else if (r_s1_valid) begin
        if (r_s1_bias) begin
          r_acc        <= '0;
          o_node_sum   <= w_sum_sat;
          o_node_index <= r_s1_node;
          o_node_valid <= 1'b1;
          o_done       <= (r_s1_node == NODE_LAST);
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_weight_mac.sv
// tb/tb_layer_weight_mac.sv - scoreboard testbench for layer_weight_mac
module tb_layer_weight_mac;

  localparam int DW    = 32;
  localparam int N_IN  = 2;
  localparam int N_OUT = 3;
  localparam int IDXW  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   i_data;
  logic            i_data_valid;
  logic            i_start;
  logic [DW-1:0]   i_weight;
  logic            i_weight_valid;
  logic            o_ram_enable;
  logic            o_rw_select;
  logic [DW-1:0]   o_node_sum;
  logic [IDXW-1:0] o_node_index;
  logic            o_node_valid;
  logic            o_busy;
  logic            o_done;

  always #5 clk = ~clk;

  layer_weight_mac #(
    .DATA_WIDTH (DW),
    .FRAC_WIDTH (16),
    .N_IN       (N_IN),
    .N_OUT      (N_OUT),
    .GUARD_BITS (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_data         (i_data),
    .i_data_valid   (i_data_valid),
    .i_start        (i_start),
    .i_weight       (i_weight),
    .i_weight_valid (i_weight_valid),
    .o_ram_enable   (o_ram_enable),
    .o_rw_select    (o_rw_select),
    .o_node_sum     (o_node_sum),
    .o_node_index   (o_node_index),
    .o_node_valid   (o_node_valid),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  typedef struct {
    logic [31:0] sum;
    int          idx;
    bit          done;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   cyc       = 0;
  int   ram_cnt   = 0;
  bit   prev_done = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic logic [31:0] model_node(input logic [31:0] x0, x1, w0, w1, b);
    longint      t0, t1, s;
    logic [63:0] r;
    t0 = clamp32((longint'($signed(x0)) * longint'($signed(w0))) >>> 16);
    t1 = clamp32((longint'($signed(x1)) * longint'($signed(w1))) >>> 16);
    s  = clamp32(t0 + t1 + longint'($signed(b)));
    r  = s;
    return r[31:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_node_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_node_valid", o_node_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("node_sum", o_node_sum, mon_e.sum);
        check_eq("node_index", o_node_index, mon_e.idx);
        check_eq("done_flag", o_done, mon_e.done);
        check_eq("valid_cycle", cyc, mon_e.cyc);
      end
    end else if (o_done) begin
      check_eq("stray_done", o_done, 0);
    end
    if (o_ram_enable) ram_cnt++;
    if (prev_done) check_eq("busy_drop", o_busy, 0);
    prev_done = o_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_start(input logic [31:0] x0, x1);
    ram_cnt      = 0;
    i_data       = x0;
    i_data_valid = 1'b1;
    tick();
    i_data  = x1;
    i_start = 1'b1;
    tick();
    i_data_valid = 1'b0;
    i_start      = 1'b0;
    i_data       = '0;
    @(negedge clk);
    check_eq("ram_enable_req", o_ram_enable, 1);
    check_eq("busy_req", o_busy, 1);
    tick();
  endtask

  task automatic stream(input logic [31:0] x0, x1, input logic [31:0] w[9], input int gap_max,
                        input bit use_lit, input logic [31:0] lit[3], input bit meddle, input bit extra);
    exp_t e;
    int   g;
    for (int i = 0; i < 9; i++) begin
      if (gap_max > 0) begin
        g = $urandom_range(1, gap_max);
        i_weight_valid = 1'b0;
        repeat (g) tick();
      end
      i_weight       = w[i];
      i_weight_valid = 1'b1;
      if (meddle && i == 4) begin
        i_start      = 1'b1;
        i_data_valid = 1'b1;
        i_data       = 32'hDEAD_BEEF;
      end
      if (i % 3 == 2) begin
        e.sum  = use_lit ? lit[i/3] : model_node(x0, x1, w[i-2], w[i-1], w[i]);
        e.idx  = i / 3;
        e.done = (i == 8);
        e.cyc  = cyc + 2;
        sb.push_back(e);
      end
      tick();
      i_start      = 1'b0;
      i_data_valid = 1'b0;
    end
    if (extra) begin
      i_weight       = 32'h0100_0000;
      i_weight_valid = 1'b1;
      tick();
    end
    i_weight_valid = 1'b0;
    i_weight       = '0;
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((sb.size() != 0 || o_busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_drained"}, sb.size(), 0);
    check_eq({tag, "_idle"}, o_busy, 0);
    check_eq({tag, "_ram_pulses"}, ram_cnt, 1);
    sb.delete();
    tick();
  endtask

  task automatic run_layer(input string tag, input logic [31:0] x0, x1, input logic [31:0] w[9],
                           input int gap_max, input bit use_lit, input logic [31:0] lit[3],
                           input bit meddle, input bit extra);
    load_start(x0, x1);
    stream(x0, x1, w, gap_max, use_lit, lit, meddle, extra);
    wait_drain(tag);
  endtask

  logic [31:0] w_a [9];
  logic [31:0] w_b [9];
  logic [31:0] w_c [9];
  logic [31:0] lit_a [3];
  logic [31:0] lit_max [3];
  logic [31:0] lit_min [3];
  logic [31:0] rx0, rx1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    i_data         = '0;
    i_data_valid   = 1'b0;
    i_start        = 1'b0;
    i_weight       = '0;
    i_weight_valid = 1'b0;

    w_a   = '{32'h0000_8000, 32'h0000_4000, 32'h0001_0000,
              32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_8000,
              32'h0000_1000, 32'hFFFF_F000, 32'h0000_0001};
    lit_a = '{32'h0002_0000, 32'h0004_8000, 32'hFFFF_F001};
    w_b   = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h0000_0000,
              32'h7FFF_0000, 32'h7FFF_0000, 32'h0000_0000,
              32'h7FFF_0000, 32'h7FFF_0000, 32'h0000_0000};
    w_c   = '{32'h8001_0000, 32'h8001_0000, 32'h0000_0000,
              32'h8001_0000, 32'h8001_0000, 32'h0000_0000,
              32'h8001_0000, 32'h8001_0000, 32'h0000_0000};
    lit_max = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    lit_min = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_node_valid", o_node_valid, 0);
    check_eq("rst_node_sum", o_node_sum, 0);
    check_eq("rst_node_index", o_node_index, 0);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_ram_enable", o_ram_enable, 0);
    check_eq("rst_rw_select", o_rw_select, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    run_layer("basic", 32'h0001_0000, 32'h0002_0000, w_a, 0, 1'b1, lit_a, 1'b0, 1'b0);
    run_layer("gaps", 32'h0001_0000, 32'h0002_0000, w_a, 3, 1'b1, lit_a, 1'b0, 1'b0);
    run_layer("sat_pos", 32'h7FFF_0000, 32'h7FFF_0000, w_b, 0, 1'b1, lit_max, 1'b0, 1'b0);
    run_layer("sat_neg", 32'h7FFF_0000, 32'h7FFF_0000, w_c, 0, 1'b1, lit_min, 1'b0, 1'b0);
    run_layer("meddle", 32'hFFFE_8000, 32'h0003_0000, w_a, 0, 1'b0, lit_a, 1'b1, 1'b1);

    i_weight       = 32'h0004_0000;
    i_weight_valid = 1'b1;
    repeat (3) tick();
    i_weight_valid = 1'b0;
    repeat (4) tick();
    check_eq("idle_weights_ignored", sb.size(), 0);

    load_start(32'h0001_0000, 32'h0002_0000);
    for (int i = 0; i < 4; i++) begin
      i_weight       = w_a[i];
      i_weight_valid = 1'b1;
      if (i == 2) begin
        mon_e.sum  = lit_a[0];
        mon_e.idx  = 0;
        mon_e.done = 1'b0;
        mon_e.cyc  = cyc + 2;
        sb.push_back(mon_e);
      end
      tick();
    end
    i_weight_valid = 1'b0;
    rst            = 1'b1;
    tick();
    @(negedge clk);
    check_eq("midrst_node_valid", o_node_valid, 0);
    check_eq("midrst_node_sum", o_node_sum, 0);
    check_eq("midrst_node_index", o_node_index, 0);
    check_eq("midrst_done", o_done, 0);
    check_eq("midrst_busy", o_busy, 0);
    check_eq("midrst_ram_enable", o_ram_enable, 0);
    check_eq("midrst_rw_select", o_rw_select, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) tick();
    check_eq("midrst_flushed", sb.size(), 0);

    for (int r = 0; r < 2; r++) begin
      rx0 = $urandom_range(32'h0004_0000, 0) - 32'h0002_0000;
      rx1 = $urandom_range(32'h0004_0000, 0) - 32'h0002_0000;
      for (int i = 0; i < 9; i++) begin
        w_c[i] = $urandom_range(32'h0008_0000, 0) - 32'h0004_0000;
      end
      run_layer("after_rst", rx0, rx1, w_c, r, 1'b0, lit_a, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
